// File: rtl/mem_write_controller.sv
// mem_write_controller
//   Drains dirty cache blocks to memory as Sysbus write transactions.
//   Up to FIFO_DEPTH (two) block writes are buffered. Each one goes onto
//   the bus as one address beat followed by BLOCKSZ/BUS_DATA_WIDTH data
//   beats. All outputs are registered.
//
// Ports
//   clk          clock
//   rst          synchronous active-low reset
//   in_address   block byte address (low 6 bits ignored)
//   data_in      block to write; beat k = data_in[64k+63:64k]
//   wr_req       enqueue request this cycle
//   wr_ready     FIFO not full; a request is taken when wr_req && wr_ready
//   wr_done      one-cycle pulse after the last data beat of a block is acked
//   bus_grant    permission to start a new transaction (sampled in IDLE only)
//   bus_owner    high from the address beat through the last data beat
//   bus_reqcyc   request valid
//   bus_req      address or data beat
//   bus_reqtag   WR_TAG during every beat, 0 otherwise
//   bus_reqack   current beat accepted
module mem_write_controller #(
  parameter int unsigned                 BLOCKSZ        = 512,
  parameter int unsigned                 BUS_DATA_WIDTH = 64,
  parameter int unsigned                 BUS_TAG_WIDTH  = 13,
  parameter logic [BUS_TAG_WIDTH-1:0]    WR_TAG         = 13'h0100,
  parameter int unsigned                 FIFO_DEPTH     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [63:0]               in_address,
  input  logic [BLOCKSZ-1:0]        data_in,
  input  logic                      wr_req,
  output logic                      wr_ready,
  output logic                      wr_done,
  input  logic                      bus_grant,
  output logic                      bus_owner,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack
);

  localparam int unsigned BEATS  = BLOCKSZ / BUS_DATA_WIDTH;
  localparam int unsigned BEAT_W = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [1:0]        FULL_CNT  = 2'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                last_ack;

  // FIFO storage and bookkeeping
  logic [63:0]         addr_mem [FIFO_DEPTH];
  logic [BLOCKSZ-1:0]  blk_mem  [FIFO_DEPTH];
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic [1:0]          count_q,  count_d;
  logic                enq, deq;

  // Registered outputs
  logic                      wr_ready_q,   wr_ready_d;
  logic                      wr_done_q,    wr_done_d;
  logic                      bus_owner_q,  bus_owner_d;
  logic                      bus_reqcyc_q, bus_reqcyc_d;
  logic [BUS_DATA_WIDTH-1:0] bus_req_q,    bus_req_d;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag_q, bus_reqtag_d;

  // wr_ready_q always mirrors (count_q != FULL), so it gates the enqueue
  // directly; a request arriving while full is simply dropped.
  assign enq = wr_req && wr_ready_q;
  assign deq = last_ack;

  always_comb begin
    rd_ptr_d = deq ? ~rd_ptr_q : rd_ptr_q;
    wr_ptr_d = enq ? ~wr_ptr_q : wr_ptr_q;
    count_d  = count_q + {1'b0, enq} - {1'b0, deq};
  end

  // Entry payload needs no reset; the count says what is valid.
  // The address is stored block-aligned so the address beat is a plain copy.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wr_ptr_q] <= in_address & ~64'h3f;
      blk_mem[wr_ptr_q]  <= data_in;
    end
  end

  // State register, FIFO pointers and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= '0;
      wr_ready_q   <= 1'b1;
      wr_done_q    <= 1'b0;
      bus_owner_q  <= 1'b0;
      bus_reqcyc_q <= 1'b0;
      bus_req_q    <= '0;
      bus_reqtag_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      wr_ready_q   <= wr_ready_d;
      wr_done_q    <= wr_done_d;
      bus_owner_q  <= bus_owner_d;
      bus_reqcyc_q <= bus_reqcyc_d;
      bus_req_q    <= bus_req_d;
      bus_reqtag_q <= bus_reqtag_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    last_ack = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((count_q != 2'd0) && bus_grant) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (bus_reqack) begin
          state_d = DATA;
          beat_d  = '0;
        end
      end
      DATA: begin
        if (bus_reqack) begin
          if (beat_q == LAST_BEAT) begin
            state_d  = IDLE;
            last_ack = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: outputs are computed from the next state so that the
  // registered copies line up with the state they describe. The head entry
  // cannot move during a transaction (rd_ptr only advances on the final
  // ack, which also leaves ADDR/DATA), so rd_ptr_q is the right index.
  always_comb begin
    wr_ready_d   = (count_d != FULL_CNT);
    wr_done_d    = last_ack;
    bus_owner_d  = (state_d != IDLE);
    bus_reqcyc_d = (state_d != IDLE);
    bus_reqtag_d = (state_d != IDLE) ? WR_TAG : '0;
    bus_req_d    = '0;
    unique case (state_d)
      ADDR:    bus_req_d = addr_mem[rd_ptr_q];
      DATA:    bus_req_d = blk_mem[rd_ptr_q][int'(beat_d) * BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
      default: bus_req_d = '0;
    endcase
  end

  assign wr_ready   = wr_ready_q;
  assign wr_done    = wr_done_q;
  assign bus_owner  = bus_owner_q;
  assign bus_reqcyc = bus_reqcyc_q;
  assign bus_req    = bus_req_q;
  assign bus_reqtag = bus_reqtag_q;

endmodule

// File: tb/tb_mem_write_controller.sv
// Testbench for mem_write_controller: directed scenarios followed by a
// randomized phase. A queue-based reference model predicts the bus beats,
// wr_ready and wr_done for every cycle; a negedge monitor compares.
module tb_mem_write_controller;

  localparam logic [12:0] WR_TAG = 13'h0100;

  typedef struct {
    logic [63:0]  addr;
    logic [511:0] blk;
  } req_t;

  logic         clk;
  logic         rst;
  logic [63:0]  in_address;
  logic [511:0] data_in;
  logic         wr_req;
  logic         wr_ready;
  logic         wr_done;
  logic         bus_grant;
  logic         bus_owner;
  logic         bus_reqcyc;
  logic [63:0]  bus_req;
  logic [12:0]  bus_reqtag;
  logic         bus_reqack;

  int checks   = 0;
  int failures = 0;

  mem_write_controller #(
    .BLOCKSZ        (512),
    .BUS_DATA_WIDTH (64),
    .BUS_TAG_WIDTH  (13),
    .WR_TAG         (13'h0100),
    .FIFO_DEPTH     (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_address (in_address),
    .data_in    (data_in),
    .wr_req     (wr_req),
    .wr_ready   (wr_ready),
    .wr_done    (wr_done),
    .bus_grant  (bus_grant),
    .bus_owner  (bus_owner),
    .bus_reqcyc (bus_reqcyc),
    .bus_req    (bus_req),
    .bus_reqtag (bus_reqtag),
    .bus_reqack (bus_reqack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + monitor ----------------
  // exp_q holds accepted, not yet completed writes; its size is the
  // occupancy and its front is the block on the bus. m_beat 0 is the
  // address beat, 1..8 are data words 0..7.
  req_t exp_q[$];
  bit   m_busy    = 1'b0;
  int   m_beat    = 0;
  bit   m_done    = 1'b0;
  bit   mon_valid = 1'b0;
  req_t head;
  logic [63:0] exp_req;

  always @(negedge clk) begin
    bit enq, deq;
    if (mon_valid) begin
      exp_req = 64'h0;
      if (m_busy && exp_q.size() != 0) begin
        head = exp_q[0];
        exp_req = (m_beat == 0) ? (head.addr & ~64'h3f) : head.blk[64*(m_beat-1) +: 64];
      end
      check("bus_reqcyc", {63'h0, bus_reqcyc}, {63'h0, m_busy});
      check("bus_owner",  {63'h0, bus_owner},  {63'h0, m_busy});
      check("bus_reqtag", {51'h0, bus_reqtag}, m_busy ? {51'h0, WR_TAG} : 64'h0);
      check("bus_req",    bus_req, exp_req);
      check("wr_ready",   {63'h0, wr_ready}, {63'h0, (exp_q.size() != 2)});
      check("wr_done",    {63'h0, wr_done},  {63'h0, m_done});
    end
    // advance the model by one cycle using this cycle's inputs
    if (rst !== 1'b1) begin
      exp_q.delete();
      m_busy    = 1'b0;
      m_beat    = 0;
      m_done    = 1'b0;
      mon_valid = 1'b1;
    end else if (mon_valid) begin
      enq = wr_req && (exp_q.size() != 2);
      deq = m_busy && bus_reqack && (m_beat == 8);
      m_done = deq;
      if (m_busy) begin
        if (bus_reqack) begin
          if (m_beat == 8) m_busy = 1'b0;
          else m_beat++;
        end
      end else if (exp_q.size() != 0 && bus_grant) begin
        m_busy = 1'b1;
        m_beat = 0;
      end
      if (deq) void'(exp_q.pop_front());
      if (enq) exp_q.push_back('{addr: in_address, blk: data_in});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_block(output logic [511:0] d);
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom();
  endtask

  task automatic set_req(input bit r);
    logic [511:0] d;
    wr_req = r;
    in_address = {$urandom(), $urandom()};
    rand_block(d);
    data_in = d;
  endtask

  task automatic drain();
    int n = 0;
    wr_req = 1'b0;
    while ((exp_q.size() != 0 || m_busy) && n < 300) begin
      cycle();
      n++;
    end
    check("drain_idle", {63'h0, (exp_q.size() != 0 || m_busy)}, 64'h0);
    repeat (2) cycle();
  endtask

  initial begin
    logic [511:0] d;
    rst        = 1'b0;
    wr_req     = 1'b0;
    in_address = '0;
    data_in    = '0;
    bus_grant  = 1'b1;
    bus_reqack = 1'b1;
    repeat (3) cycle();
    rst = 1'b1;
    cycle();

    // single write, words 0..7
    wr_req     = 1'b1;
    in_address = 64'h1000_0047;
    for (int k = 0; k < 8; k++) d[64*k +: 64] = 64'(k);
    data_in = d;
    cycle();
    wr_req = 1'b0;
    drain();

    // three back-to-back requests, third one rejected
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1);
      cycle();
    end
    drain();

    // ack stalls: three cycles on the address beat and on data beat 4
    set_req(1'b1);
    cycle();                       // cycle 1
    wr_req = 1'b0;
    cycle();                       // cycle 2: address beat
    bus_reqack = 1'b0;
    repeat (3) cycle();            // cycles 2..4 stalled
    bus_reqack = 1'b1;
    repeat (5) cycle();            // cycles 5..9
    bus_reqack = 1'b0;             // cycle 10: data beat 4
    repeat (3) cycle();
    bus_reqack = 1'b1;
    drain();

    // grant withheld for five cycles, then dropped during data beats
    bus_grant = 1'b0;
    set_req(1'b1);
    cycle();
    wr_req = 1'b0;
    repeat (4) cycle();
    bus_grant = 1'b1;
    repeat (3) cycle();
    bus_grant = 1'b0;
    drain();
    bus_grant = 1'b1;

    // full FIFO with wr_req held through the last ack
    set_req(1'b1);
    cycle();
    set_req(1'b1);
    cycle();
    set_req(1'b1);
    repeat (10) cycle();           // held through cycle 11
    wr_req = 1'b0;
    drain();

    // reset during data beat 3 with a second entry pending
    set_req(1'b1);
    cycle();
    set_req(1'b1);
    cycle();
    wr_req = 1'b0;
    repeat (4) cycle();            // now in cycle 6: data beat 3
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    repeat (12) cycle();

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      set_req($urandom_range(0, 3) == 0);
      bus_grant  = ($urandom_range(0, 7) != 0);
      bus_reqack = ($urandom_range(0, 3) != 0);
      rst        = ($urandom_range(0, 399) != 0);
      cycle();
    end
    rst        = 1'b1;
    bus_grant  = 1'b1;
    bus_reqack = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
